spi_reg_sequencer: RTL and testbench

Host-side controller that drives the raybox-zero SPI register port. It arbitrates register-write requests from two on-chip requesters and serialises each one as a command-plus-payload SPI frame. It also issues the once-per-vertical-blank `load_new` strobe that commits the receiver's buffered values to its live registers.

---
 rtl/spi_reg_sequencer_if.sv | 24 ++
 rtl/spi_reg_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_spi_reg_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_reg_sequencer_if.sv
// Request side of spi_reg_sequencer: two valid/ready register-write requesters.
// The requesters drive the master modport; the sequencer uses the slave modport.
interface spi_reg_sequencer_if;
  logic        req0_valid;
  logic [3:0]  req0_cmd;
  logic [23:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [3:0]  req1_cmd;
  logic [23:0] req1_data;
  logic        req1_ready;

  modport master (
    output req0_valid, req0_cmd, req0_data,
    output req1_valid, req1_cmd, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_cmd, req0_data,
    input  req1_valid, req1_cmd, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/spi_reg_sequencer.sv
// Host-side sequencer for the raybox-zero SPI register port: round-robin arbitration of
// two write requesters, mode-0 MSB-first framing, and the once-per-vblank load_new commit.
module spi_reg_sequencer #(
  parameter int HALF = 2,
  parameter int GAP  = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  spi_reg_sequencer_if.slave req,
  input  logic               vblank,
  output logic               o_sclk,
  output logic               o_ss_n,
  output logic               o_mosi,
  output logic               load_new,
  output logic               busy,
  output logic               frame_done,
  output logic               err
);

  localparam int TMAX    = (HALF > GAP) ? HALF : GAP;
  localparam int TW      = $clog2(TMAX + 1);
  localparam int FRAME_W = 28;

  localparam logic [TW-1:0] T_HALF = TW'(HALF - 1);
  localparam logic [TW-1:0] T_GAP  = TW'(GAP - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  state_t               state_q;
  logic                 ptr_q;
  logic                 armed_q;
  logic [TW-1:0]        timer_q;
  logic [4:0]           bit_q;
  logic [FRAME_W-1:0]   shreg_q;
  logic                 sclk_q;
  logic                 ss_n_q;
  logic                 mosi_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 load_q;

  function automatic logic [4:0] payload_len(input logic [3:0] cmd);
    case (cmd)
      4'd0, 4'd1, 4'd2, 4'd4:   payload_len = 5'd6;
      4'd3:                     payload_len = 5'd12;
      4'd5:                     payload_len = 5'd1;
      4'd6:                     payload_len = 5'd16;
      4'd7, 4'd8, 4'd9, 4'd10:  payload_len = 5'd24;
      default:                  payload_len = 5'd0;
    endcase
  endfunction

  // Left-align the frame so the shifter always emits from the top bit; bits above LEN drop out.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]  cmd,
                                                     input logic [23:0] data,
                                                     input logic [4:0]  len);
    logic [23:0] aligned;
    aligned     = data << (5'd24 - len);
    build_frame = {cmd, aligned};
  endfunction

  logic               blocked;
  logic               can_grant;
  logic               gnt0;
  logic               gnt1;
  logic               gnt_any;
  logic               cmd_ok;
  logic               idle_d;
  logic [3:0]         sel_cmd;
  logic [23:0]        sel_data;
  logic [4:0]         sel_len;
  logic [FRAME_W-1:0] sel_frame;

  // The commit owns the idle slot while it is pending and on the cycle it is issued.
  always_comb begin
    blocked   = (vblank & armed_q) | load_q;
    can_grant = (state_q == S_IDLE) & ~blocked;
    gnt0      = can_grant & req.req0_valid & (~req.req1_valid | ~ptr_q);
    gnt1      = can_grant & req.req1_valid & (~req.req0_valid | ptr_q);
    gnt_any   = gnt0 | gnt1;
    sel_cmd   = gnt1 ? req.req1_cmd  : req.req0_cmd;
    sel_data  = gnt1 ? req.req1_data : req.req0_data;
    sel_len   = payload_len(sel_cmd);
    cmd_ok    = (sel_cmd <= 4'd10);
    sel_frame = build_frame(sel_cmd, sel_data, sel_len);
    idle_d    = ((state_q == S_IDLE) & ~(gnt_any & cmd_ok)) |
                ((state_q == S_GAP) & (timer_q == '0));
  end

  assign req.req0_ready = gnt0;
  assign req.req1_ready = gnt1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      armed_q <= 1'b1;
      timer_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      load_q <= 1'b0;

      // Looking at the next state lets the commit land on the IDLE-entry cycle itself.
      if (!vblank) begin
        armed_q <= 1'b1;
      end else if (armed_q && idle_d) begin
        armed_q <= 1'b0;
        load_q  <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (gnt_any) begin
            ptr_q <= gnt0;
            if (cmd_ok) begin
              state_q <= S_SETUP;
              ss_n_q  <= 1'b0;
              sclk_q  <= 1'b0;
              mosi_q  <= sel_frame[FRAME_W-1];
              shreg_q <= sel_frame << 1;
              bit_q   <= sel_len + 5'd4;
              timer_q <= T_HALF;
              busy_q  <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (timer_q == '0) begin
            state_q <= S_SHIFT;
            sclk_q  <= 1'b1;
            bit_q   <= bit_q - 5'd1;
            timer_q <= T_HALF;
          end else begin
            timer_q <= timer_q - T_ONE;
          end
        end
        // bit_q counts rising edges still to come; the fall after the last rise ends SHIFT.
        S_SHIFT: begin
          if (timer_q == '0) begin
            timer_q <= T_HALF;
            if (sclk_q) begin
              sclk_q <= 1'b0;
              if (bit_q == '0) begin
                state_q <= S_HOLD;
              end else begin
                mosi_q  <= shreg_q[FRAME_W-1];
                shreg_q <= shreg_q << 1;
              end
            end else begin
              sclk_q <= 1'b1;
              bit_q  <= bit_q - 5'd1;
            end
          end else begin
            timer_q <= timer_q - T_ONE;
          end
        end
        S_HOLD: begin
          if (timer_q == '0) begin
            state_q <= S_GAP;
            ss_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            timer_q <= T_GAP;
          end else begin
            timer_q <= timer_q - T_ONE;
          end
        end
        S_GAP: begin
          if (timer_q == '0) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            timer_q <= timer_q - T_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ss_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sclk     = sclk_q;
  assign o_ss_n     = ss_n_q;
  assign o_mosi     = mosi_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign err        = err_q;
  assign load_new   = load_q;

endmodule

// File: tb/tb_spi_reg_sequencer.sv
// Bench for spi_reg_sequencer: a timing-formula reference model checked every cycle,
// directed scenarios with hand-computed expectations, then a randomized traffic phase.
module tb_spi_reg_sequencer;
  localparam int HALF = 2;
  localparam int GAP  = 4;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic vblank  = 1'b0;
  logic o_sclk, o_ss_n, o_mosi, load_new, busy, frame_done, err;

  spi_reg_sequencer_if ifc ();

  spi_reg_sequencer #(.HALF(HALF), .GAP(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .req(ifc.slave), .vblank(vblank),
    .o_sclk(o_sclk), .o_ss_n(o_ss_n), .o_mosi(o_mosi), .load_new(load_new),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // model state
  bit   m_act;
  int   m_g;
  int   m_F;
  logic m_bits [0:27];
  bit   m_ptr, m_armed, exp_err_q, exp_ld_q, m_hs0, m_hs1;
  int   gnt_q[$];
  int   last_gcyc = 0;

  // observation captures
  int          cap_rises, cap_ss_low, cap_busy, cap_err, cap_load;
  int          fd_cyc, fd_first, ld_cyc, err_cyc;
  logic [31:0] cap_bits;
  logic        prev_sclk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int plen(input int c);
    case (c)
      0, 1, 2, 4:   return 6;
      3:            return 12;
      5:            return 1;
      6:            return 16;
      7, 8, 9, 10:  return 24;
      default:      return 0;
    endcase
  endfunction

  // Cycle, relative to the grant, on which the sequencer is back in IDLE with frame_done.
  function automatic int frame_end(input int f);
    return 1 + (2 * f + 1) * HALF + GAP;
  endfunction

  task automatic clear_caps();
    cap_rises = 0; cap_ss_low = 0; cap_busy = 0; cap_err = 0; cap_load = 0;
    fd_cyc = -1; fd_first = -1; ld_cyc = -1; err_cyc = -1; cap_bits = '0;
  endtask

  always @(negedge clk) begin : mon
    int r, k, idx, L;
    logic e_ss, e_sclk, e_mosi, e_busy, e_fd, blk, e_r0, e_r1, idle_n, new_ld;
    logic [3:0]  c;
    logic [23:0] d;
    if (!reset_n) begin
      m_act = 0; m_ptr = 0; m_armed = 1; exp_err_q = 0; exp_ld_q = 0;
      m_hs0 = 0; m_hs1 = 0; prev_sclk = 0;
    end else begin
      e_ss = 1; e_sclk = 0; e_mosi = 0; e_busy = 0; e_fd = 0;
      if (m_act) begin
        r = cyc - m_g;
        if (r >= 1 && r < 1 + (2 * m_F + 1) * HALF) begin
          e_ss   = 0;
          k      = (r - 1) / HALF;
          e_sclk = (k % 2 == 1);
          idx    = (k / 2 < m_F) ? k / 2 : m_F - 1;
          e_mosi = m_bits[idx];
        end
        e_busy = (r >= 1 && r < frame_end(m_F));
        e_fd   = (r == frame_end(m_F));
        if (r >= frame_end(m_F)) m_act = 0;
      end
      blk  = (vblank && m_armed) || exp_ld_q;
      e_r0 = !m_act && !blk && ifc.req0_valid && (!ifc.req1_valid || !m_ptr);
      e_r1 = !m_act && !blk && ifc.req1_valid && (!ifc.req0_valid || m_ptr);

      check("ss_n", o_ss_n, e_ss);
      check("sclk", o_sclk, e_sclk);
      check("mosi", o_mosi, e_mosi);
      check("busy", busy, e_busy);
      check("frame_done", frame_done, e_fd);
      check("err", err, exp_err_q);
      check("load_new", load_new, exp_ld_q);
      check("ready0", ifc.req0_ready, e_r0);
      check("ready1", ifc.req1_ready, e_r1);
      check("ready_while_busy", (ifc.req0_ready | ifc.req1_ready) & busy, 0);

      if (o_sclk && !prev_sclk) begin
        cap_rises++;
        cap_bits = {cap_bits[30:0], o_mosi};
      end
      prev_sclk = o_sclk;
      if (!o_ss_n) cap_ss_low++;
      if (busy) cap_busy++;
      if (err) begin cap_err++; err_cyc = cyc; end
      if (load_new) begin cap_load++; ld_cyc = cyc; end
      if (frame_done) begin
        fd_cyc = cyc;
        if (fd_first < 0) fd_first = cyc;
      end

      // advance the model to the next cycle
      m_hs0 = e_r0; m_hs1 = e_r1; exp_err_q = 0;
      if (e_r0 || e_r1) begin
        c = e_r1 ? ifc.req1_cmd  : ifc.req0_cmd;
        d = e_r1 ? ifc.req1_data : ifc.req0_data;
        gnt_q.push_back(e_r1 ? 1 : 0);
        last_gcyc = cyc;
        m_ptr = e_r0;
        if (c > 4'd10) begin
          exp_err_q = 1;
        end else begin
          m_act = 1; m_g = cyc; L = plen(int'(c)); m_F = 4 + L;
          for (int j = 0; j < m_F; j++) m_bits[j] = (j < 4) ? c[3 - j] : d[L - 1 - (j - 4)];
        end
      end
      idle_n = !m_act || ((cyc + 1 - m_g) >= frame_end(m_F));
      new_ld = 0;
      if (!vblank) m_armed = 1;
      else if (m_armed && idle_n) begin new_ld = 1; m_armed = 0; end
      exp_ld_q = new_ld;
    end
  end

  task automatic send(input int which, input logic [3:0] c, input logic [23:0] d, output int gc);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    if (which == 0) begin ifc.req0_valid = 1; ifc.req0_cmd = c; ifc.req0_data = d; end
    else            begin ifc.req1_valid = 1; ifc.req1_cmd = c; ifc.req1_data = d; end
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (which == 0) ? m_hs0 : m_hs1;
    end
    gc = last_gcyc;
    if (which == 0) begin
      ifc.req0_valid = 0; ifc.req0_cmd = 4'($urandom); ifc.req0_data = 24'($urandom);
    end else begin
      ifc.req1_valid = 0; ifc.req1_cmd = 4'($urandom); ifc.req1_data = 24'($urandom);
    end
    if (!ok) check("handshake_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      ok = !m_act && !busy;
    end
    if (!ok) check("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int gc, g2, rc, a0, a1, a2;
    bit ok;
    ifc.req0_valid = 0; ifc.req0_cmd = '0; ifc.req0_data = '0;
    ifc.req1_valid = 0; ifc.req1_cmd = '0; ifc.req1_data = '0;
    clear_caps();

    @(posedge clk); #1;
    check("rst_ss_n", o_ss_n, 1);
    check("rst_sclk", o_sclk, 0);
    check("rst_mosi", o_mosi, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err", err, 0);
    check("rst_load_new", load_new, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (3) @(posedge clk);
    #1;

    // single sky write
    clear_caps();
    send(0, 4'd0, 24'h00002A, gc);
    repeat (60) @(posedge clk);
    #1;
    check("sky_rises", cap_rises, 10);
    check("sky_bits", cap_bits & 32'h3FF, 32'h02A);
    check("sky_ss_low_cycles", cap_ss_low, 42);
    check("sky_busy_cycles", cap_busy, 46);
    check("sky_done_cycle", fd_cyc - gc, 47);

    // invalid command on req1
    clear_caps();
    send(1, 4'd12, 24'h123456, gc);
    repeat (5) @(posedge clk);
    #1;
    check("inv_err_count", cap_err, 1);
    check("inv_err_cycle", err_cyc - gc, 1);
    check("inv_ss_low", cap_ss_low, 0);
    check("inv_busy", cap_busy, 0);

    // contention: both requesters valid continuously
    clear_caps();
    gnt_q.delete();
    @(posedge clk); #1;
    ifc.req0_valid = 1; ifc.req0_cmd = 4'd7; ifc.req0_data = 24'hABCDEF;
    ifc.req1_valid = 1; ifc.req1_cmd = 4'd3; ifc.req1_data = 24'h000FC3;
    ok = 0;
    for (int i = 0; i < 800 && !ok; i++) begin
      @(posedge clk); #1;
      ok = (gnt_q.size() >= 3);
    end
    ifc.req0_valid = 0; ifc.req1_valid = 0;
    if (!ok) check("cont_timeout", 0, 1);
    wait_idle();
    a0 = (gnt_q.size() > 0) ? gnt_q[0] : -1;
    a1 = (gnt_q.size() > 1) ? gnt_q[1] : -1;
    a2 = (gnt_q.size() > 2) ? gnt_q[2] : -1;
    check("cont_grant_count", gnt_q.size(), 3);
    check("cont_grant0", a0, 0);
    check("cont_grant1", a1, 1);
    check("cont_grant2", a2, 0);
    check("cont_rises", cap_rises, 72);

    // vblank rises mid-frame with a request pending
    clear_caps();
    send(0, 4'd6, 24'h00BEEF, gc);
    repeat (15) @(posedge clk);
    #1 vblank = 1;
    send(1, 4'd1, 24'h000015, g2);
    wait_idle();
    repeat (20) @(posedge clk);
    #1 vblank = 0;
    repeat (3) @(posedge clk);
    #1;
    check("vb_load_count", cap_load, 1);
    check("vb_load_cycle", ld_cyc - gc, 87);
    check("vb_load_with_done", ld_cyc, fd_first);
    check("vb_grant_after_load", g2 > ld_cyc, 1);

    // minimum frame
    clear_caps();
    send(0, 4'd5, 24'h000001, gc);
    wait_idle();
    check("min_rises", cap_rises, 5);
    check("min_bits", cap_bits & 32'h1F, 32'h0B);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      if (!ifc.req0_valid || m_hs0) begin
        if ($urandom_range(0, 3) == 0) begin
          ifc.req0_valid = 1;
          ifc.req0_cmd   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
          ifc.req0_data  = 24'($urandom);
        end else begin
          ifc.req0_valid = 0;
        end
      end
      if (!ifc.req1_valid || m_hs1) begin
        if ($urandom_range(0, 3) == 0) begin
          ifc.req1_valid = 1;
          ifc.req1_cmd   = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
          ifc.req1_data  = 24'($urandom);
        end else begin
          ifc.req1_valid = 0;
        end
      end
      if ($urandom_range(0, 59) == 0) vblank = ~vblank;
    end
    ifc.req0_valid = 0; ifc.req1_valid = 0; vblank = 0;
    wait_idle();

    // reset during SHIFT
    clear_caps();
    send(0, 4'd7, 24'hABCDEF, gc);
    repeat (30) @(posedge clk);
    #2 reset_n = 0;
    #1;
    check("mrst_ss_n", o_ss_n, 1);
    check("mrst_sclk", o_sclk, 0);
    check("mrst_busy", busy, 0);
    vblank = 1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    rc = cyc;
    clear_caps();
    repeat (5) @(posedge clk);
    #1;
    check("mrst_load_count", cap_load, 1);
    check("mrst_load_cycle", ld_cyc - rc, 1);
    check("mrst_no_frame", cap_ss_low, 0);
    vblank = 0;
    repeat (5) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
